// File: rtl/hack_ram_reader.sv
// Burst read engine: walks `count` addresses of a registered-read Hack RAM and streams words on valid/ready.
// Optional HACK_READER_WRAP_EN: wrap mem_addr past the top instead of truncating the burst.
module hack_ram_reader #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              rv_q;
  logic [WIDTH-1:0]  fifo_q [2];
  logic              wptr_q, rptr_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W:0]   issue_left_q, accept_left_q;
  logic              busy_q, zdone_q;

  logic              push, pop, credit_ok, last_pop;
  logic [1:0]        cnt_d;
  logic [ADDR_W:0]   total;
`ifndef HACK_READER_WRAP_EN
  logic [ADDR_W:0]   room;
`endif

  always_comb begin
    push      = rv_q;
    pop       = (cnt_q != 2'd0) && out_ready;
    cnt_d     = cnt_q + 2'(push) - 2'(pop);
    // Occupancy after this edge plus the read still on its way in must leave room for one more.
    credit_ok = ({1'b0, cnt_d} + {2'b00, rd_q}) < 3'd2;
    last_pop  = (state_q == S_DRAIN) && pop && (accept_left_q == (ADDR_W+1)'(1));
`ifdef HACK_READER_WRAP_EN
    total     = count;
`else
    room      = ((ADDR_W+1)'(1) << ADDR_W) - {1'b0, base_addr};
    total     = (count > room) ? room : count;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rd_q          <= 1'b0;
      rv_q          <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wptr_q        <= 1'b0;
      rptr_q        <= 1'b0;
      cnt_q         <= 2'd0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
      busy_q        <= 1'b0;
      zdone_q       <= 1'b0;
    end else begin
      rv_q    <= rd_q;
      cnt_q   <= cnt_d;
      zdone_q <= 1'b0;
      if (push) begin
        fifo_q[wptr_q] <= mem_rdata;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q        <= ~rptr_q;
        accept_left_q <= accept_left_q - (ADDR_W+1)'(1);
      end
      case (state_q)
        S_IDLE: begin
          rd_q <= 1'b0;
          if (start) begin
            busy_q        <= 1'b1;
            accept_left_q <= total;
            issue_left_q  <= total;
            if (total == '0) begin
              state_q <= S_DRAIN;
            end else begin
              // First read goes out with the accepting edge to hit the 2-cycle first-word latency.
              rd_q         <= 1'b1;
              addr_q       <= base_addr;
              issue_left_q <= total - (ADDR_W+1)'(1);
              state_q      <= (total == (ADDR_W+1)'(1)) ? S_DRAIN : S_READ;
            end
          end
        end
        S_READ: begin
          if (credit_ok) begin
            rd_q         <= 1'b1;
            addr_q       <= addr_q + ADDR_W'(1);
            issue_left_q <= issue_left_q - (ADDR_W+1)'(1);
            if (issue_left_q == (ADDR_W+1)'(1)) state_q <= S_DRAIN;
          end else begin
            rd_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          rd_q <= 1'b0;
          if (accept_left_q == '0) begin
            zdone_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (last_pop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = fifo_q[rptr_q];
  assign busy      = busy_q;
  assign done      = zdone_q | last_pop;

endmodule

// File: tb/tb_hack_ram_reader.sv
// Scoreboard bench for hack_ram_reader: RAM model mem[a]=a+0x100, expected words queued at start.
module tb_hack_ram_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] count = '0;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done;

  hack_ram_reader #(.WIDTH(16), .ADDR_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= {2'b00, mem_addr} + 16'h0100;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        clr_req = 1'b0;
  int          n_rd, n_hs, n_done, n_valid, n_busy, first_v, last_hs, done_cyc, max_out, stall_err;
  logic        prev_stall;
  logic [15:0] prev_d;

  always @(negedge clk) begin
    if (clr_req) begin
      n_rd = 0; n_hs = 0; n_done = 0; n_valid = 0; n_busy = 0;
      first_v = -1; last_hs = -1; done_cyc = -1; max_out = 0; stall_err = 0;
      prev_stall = 1'b0; prev_d = '0;
    end else if (reset_n) begin
      if (mem_rd) n_rd++;
      if (busy) n_busy++;
      if (out_valid) begin
        n_valid++;
        if (first_v < 0) first_v = cyc;
      end
      if (prev_stall && !(out_valid && out_data == prev_d)) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      if (out_valid && out_ready) begin
        n_hs++;
        last_hs = cyc;
        if (exp_q.size() == 0) chk("extra_word_sb_depth", 32'(exp_q.size()), 32'd1);
        else chk("data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
      if (n_rd - n_hs > max_out) max_out = n_rd - n_hs;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  logic bp_mode = 1'b0;
  int   bp_idx = 0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) begin
      out_ready = (bp_idx % 3 == 0);
      bp_idx++;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic clr_stats();
    clr_req = 1'b1;
    @(negedge clk); #1;
    clr_req = 1'b0;
  endtask

  task automatic start_burst(input logic [13:0] b, input logic [14:0] c, output int sc, output int tot);
    int t;
    t = int'(c);
`ifndef HACK_READER_WRAP_EN
    if (t > 16384 - int'(b)) t = 16384 - int'(b);
`endif
    for (int i = 0; i < t; i++) begin
      logic [13:0] a;
      a = b + 14'(i);
      exp_q.push_back({2'b00, a} + 16'h0100);
    end
    @(posedge clk); #1;
    base_addr = b; count = c; start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    tot = t;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) @(posedge clk);
    chk("done_seen", 32'(n_done), 32'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_addr"}, {18'h0, mem_addr}, 32'h0);
    chk({pfx, "_mem_rd"}, {31'h0, mem_rd}, 32'h0);
    chk({pfx, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    chk({pfx, "_out_data"}, {16'h0, out_data}, 32'h0);
    chk({pfx, "_busy"}, {31'h0, busy}, 32'h0);
    chk({pfx, "_done"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int sc, tot;
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    int sc, tot;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset_n = 1'b1;

    // Streaming, out_ready held high
    clr_stats();
    start_burst(14'h0020, 15'd4, sc, tot);
    wait_done(60);
    chk("t2_handshakes", 32'(n_hs), 32'd4);
    chk("t2_reads", 32'(n_rd), 32'd4);
    chk("t2_first_valid_cyc", 32'(first_v), 32'(sc + 3));
    chk("t2_done_on_last_hs", 32'(done_cyc), 32'(last_hs));
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_busy_after", {31'h0, busy}, 32'h0);

    // Backpressure 1,0,0 pattern
    clr_stats();
    bp_mode = 1'b1;
    start_burst(14'h0020, 15'd4, sc, tot);
    wait_done(100);
    bp_mode = 1'b0;
    chk("t3_handshakes", 32'(n_hs), 32'd4);
    chk("t3_outstanding_over2", 32'(max_out > 2), 32'd0);
    chk("t3_stall_unstable", 32'(stall_err), 32'd0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero count
    clr_stats();
    start_burst(14'h0100, 15'd0, sc, tot);
    wait_done(20);
    chk("t4_reads", 32'(n_rd), 32'd0);
    chk("t4_valid_cycles", 32'(n_valid), 32'd0);
    chk("t4_done_cyc", 32'(done_cyc), 32'(sc + 2));
    chk("t4_busy_cycles", 32'(n_busy), 32'd1);

    // Start while busy is ignored
    clr_stats();
    start_burst(14'h0040, 15'd3, sc, tot);
    chk("t5_busy_at_restart", {31'h0, busy}, 32'h1);
    base_addr = 14'h0100; count = 15'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_handshakes", 32'(n_hs), 32'd3);
    chk("t5_reads", 32'(n_rd), 32'd3);
    chk("t5_done_count", 32'(n_done), 32'd1);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Top address boundary
    clr_stats();
    start_burst(14'h3FFE, 15'd4, sc, tot);
    wait_done(60);
    chk("t6_handshakes", 32'(n_hs), 32'(tot));
    chk("t6_reads", 32'(n_rd), 32'(tot));
    chk("t6_done_count", 32'(n_done), 32'd1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst
    clr_stats();
    start_burst(14'h0010, 15'd5, sc, tot);
    for (int i = 0; i < 50 && n_hs < 2; i++) @(negedge clk);
    chk("t1_two_hs_before_reset", 32'(n_hs), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk_zero("t1_mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clr_stats();
    start_burst(14'h0000, 15'd1, sc, tot);
    wait_done(30);
    chk("t1_handshakes", 32'(n_hs), 32'd1);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
